// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : button_conditioner
//  Purpose  : Turns raw, bouncy, active-low push buttons into clean
//             clock-synchronous level / press / release signals. Each channel
//             has a 2-flop synchronizer, a counter-based debounce FSM and
//             registered single-cycle edge pulses. press[i] is the load
//             strobe consumed downstream, so one physical press yields one
//             strobe regardless of contact bounce.
//             "release" is a reserved word, so that pulse is release_pulse.
//  Revision : 1.0  initial release
// ============================================================================
module button_conditioner #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_pulse,
    output logic             any_held
);

    // Counter width is derived from the debounce length, never overridden.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RELEASED  = 2'b00,
        ST_ARMING    = 2'b01,
        ST_PRESSED   = 2'b10,
        ST_DISARMING = 2'b11
    } state_t;

    logic [N_BTN-1:0] level_d, press_d, release_d;
    logic [N_BTN-1:0] level_q, press_q, release_q;
    logic             any_held_d, any_held_q;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic             s1_q, s1_d;
        logic             s2_q, s2_d;
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             press_nxt, release_nxt;

        // Synchronizer and debounce state; sync flops reset to "released".
        always_ff @(posedge Clk or posedge reset) begin
            if (reset) begin
                s1_q    <= 1'b1;
                s2_q    <= 1'b1;
                state_q <= ST_RELEASED;
                cnt_q   <= '0;
            end else begin
                s1_q    <= s1_d;
                s2_q    <= s2_d;
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Debounce FSM: counter compared before increment and cleared on
        // every state change, so it can never wrap.
        always_comb begin
            s1_d        = btn_n[i];
            s2_d        = s1_q;
            state_d     = state_q;
            cnt_d       = cnt_q;
            press_nxt   = 1'b0;
            release_nxt = 1'b0;
            case (state_q)
                ST_RELEASED: begin
                    if (!s2_q) begin
                        state_d = ST_ARMING;
                        cnt_d   = '0;
                    end
                end
                ST_ARMING: begin
                    if (s2_q) begin
                        state_d = ST_RELEASED;
                        cnt_d   = '0;
                    end else if (cnt_q == c_cnt_max) begin
                        state_d   = ST_PRESSED;
                        cnt_d     = '0;
                        press_nxt = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (s2_q) begin
                        state_d = ST_DISARMING;
                        cnt_d   = '0;
                    end
                end
                ST_DISARMING: begin
                    if (!s2_q) begin
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == c_cnt_max) begin
                        state_d     = ST_RELEASED;
                        cnt_d       = '0;
                        release_nxt = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end
            endcase
        end

        // Level follows the next state so it moves in the same cycle as the pulse.
        assign level_d[i]   = (state_d == ST_PRESSED) || (state_d == ST_DISARMING);
        assign press_d[i]   = press_nxt;
        assign release_d[i] = release_nxt;
    end

    // any_held is built from next-state levels so it aligns with level.
    always_comb begin
        any_held_d = |level_d;
    end

    // Registered outputs.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            level_q    <= '0;
            press_q    <= '0;
            release_q  <= '0;
            any_held_q <= 1'b0;
        end else begin
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            any_held_q <= any_held_d;
        end
    end

    assign level         = level_q;
    assign press         = press_q;
    assign release_pulse = release_q;
    assign any_held      = any_held_q;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_conditioner
//  Purpose  : Self-checking bench for button_conditioner (N_BTN=2,
//             DEBOUNCE_CYCLES=4). Directed tasks check hand-derived timing;
//             a run-length reference model feeds a scoreboard for the
//             randomized bounce run.
//  Revision : 1.0  initial release
// ============================================================================
module tb_button_conditioner;

    localparam int N   = 2;
    localparam int D   = 4;
    // Inputs change just after a falling edge. The first rising edge that
    // samples the new value is edge k; the pulse appears after edge k+2+D,
    // i.e. on the (D+3)-th rising edge after the change.
    localparam int LAT = D + 3;

    logic         Clk   = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] btn_n = '1;
    logic [N-1:0] level, press, release_pulse;
    logic         any_held;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    button_conditioner #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .Clk           (Clk),
        .reset         (reset),
        .btn_n         (btn_n),
        .level         (level),
        .press         (press),
        .release_pulse (release_pulse),
        .any_held      (any_held)
    );

    // ------------------------------------------------------------------
    // Reference model: a pin delayed two clocks must disagree with the
    // debounced level for D+1 consecutive rising edges before it toggles.
    // ------------------------------------------------------------------
    logic [N-1:0]  m_s1 = '1, m_s2 = '1, m_lvl = '0, m_press = '0, m_rel = '0;
    int            m_run [N];
    bit            sb_en = 1'b0;
    int            m_press_cnt = 0;
    logic [3*N:0]  sb_q [$];

    initial begin
        forever begin
            @(posedge Clk or posedge reset);
            if (reset) begin
                m_s1 = '1; m_s2 = '1; m_lvl = '0; m_press = '0; m_rel = '0;
                for (int c = 0; c < N; c++) m_run[c] = 0;
            end else begin
                m_press = '0;
                m_rel   = '0;
                for (int c = 0; c < N; c++) begin
                    if (~m_s2[c] != m_lvl[c]) begin
                        m_run[c] = m_run[c] + 1;
                        if (m_run[c] == D + 1) begin
                            m_lvl[c] = ~m_lvl[c];
                            m_run[c] = 0;
                            if (m_lvl[c]) begin
                                m_press[c] = 1'b1;
                                if (sb_en) m_press_cnt++;
                            end else begin
                                m_rel[c] = 1'b1;
                            end
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end
                m_s2 = m_s1;
                m_s1 = btn_n;
                if (sb_en) sb_q.push_back({m_lvl, m_press, m_rel, |m_lvl});
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b1;
        btn_n = '1;
        repeat (3) @(negedge Clk);
        n_checks++; if (level !== '0) begin n_errors++; $display("FAIL reset_level: got %b expected 00", level); end
        n_checks++; if (press !== '0) begin n_errors++; $display("FAIL reset_press: got %b expected 00", press); end
        n_checks++; if (release_pulse !== '0) begin n_errors++; $display("FAIL reset_release: got %b expected 00", release_pulse); end
        n_checks++; if (any_held !== 1'b0) begin n_errors++; $display("FAIL reset_any_held: got %b expected 0", any_held); end
        btn_n[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            n_checks++;
            if (press !== '0 || level !== '0) begin
                n_errors++;
                $display("FAIL reset_hold cycle %0d: press=%b level=%b expected 00/00", i, press, level);
            end
        end
        btn_n = '1;
        repeat (3) @(negedge Clk);
        reset = 1'b0;
        repeat (3) @(negedge Clk);
        n_checks++;
        if ({level, press, release_pulse, any_held} !== '0) begin
            n_errors++;
            $display("FAIL reset_exit: got %b expected all zero", {level, press, release_pulse, any_held});
        end
    endtask

    task automatic test_clean_press();
        logic [N-1:0] exp_p;
        @(negedge Clk);
        btn_n[0] = 1'b0;
        for (int i = 1; i <= LAT + 1; i++) begin
            @(negedge Clk);
            exp_p = (i == LAT) ? 2'b01 : 2'b00;
            n_checks++;
            if (press !== exp_p) begin
                n_errors++;
                $display("FAIL clean_press edge %0d: got %b expected %b", i, press, exp_p);
            end
            if (i == LAT - 1) begin
                n_checks++;
                if (level !== 2'b00) begin n_errors++; $display("FAIL clean_press_early_level: got %b expected 00", level); end
            end
        end
        n_checks++; if (level !== 2'b01) begin n_errors++; $display("FAIL clean_press_level: got %b expected 01", level); end
        n_checks++; if (any_held !== 1'b1) begin n_errors++; $display("FAIL clean_press_any_held: got %b expected 1", any_held); end
    endtask

    task automatic test_release();
        logic [N-1:0] exp_r;
        @(negedge Clk);
        btn_n[0] = 1'b1;
        repeat (2) @(negedge Clk);
        btn_n[0] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            n_checks++;
            if (release_pulse !== 2'b00 || level !== 2'b01) begin
                n_errors++;
                $display("FAIL release_glitch cycle %0d: release=%b level=%b expected 00/01", i, release_pulse, level);
            end
        end
        btn_n[0] = 1'b1;
        for (int i = 1; i <= LAT + 1; i++) begin
            @(negedge Clk);
            exp_r = (i == LAT) ? 2'b01 : 2'b00;
            n_checks++;
            if (release_pulse !== exp_r) begin
                n_errors++;
                $display("FAIL clean_release edge %0d: got %b expected %b", i, release_pulse, exp_r);
            end
        end
        n_checks++; if (level !== 2'b00) begin n_errors++; $display("FAIL release_level: got %b expected 00", level); end
        n_checks++; if (any_held !== 1'b0) begin n_errors++; $display("FAIL release_any_held: got %b expected 0", any_held); end
    endtask

    task automatic test_bounce();
        // low 3, high 1, low 3, then high: never D+1 stable samples.
        for (int i = 0; i < 19; i++) begin
            @(negedge Clk);
            n_checks++;
            if (press !== 2'b00 || level !== 2'b00) begin
                n_errors++;
                $display("FAIL bounce cycle %0d: press=%b level=%b expected 00/00", i, press, level);
            end
            btn_n[0] = (i < 3) ? 1'b0 : (i == 3) ? 1'b1 : (i < 7) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic test_simultaneous();
        logic [N-1:0] exp_v;
        @(negedge Clk);
        btn_n = 2'b00;
        for (int i = 1; i <= LAT + 1; i++) begin
            @(negedge Clk);
            exp_v = (i == LAT) ? 2'b11 : 2'b00;
            n_checks++;
            if (press !== exp_v) begin
                n_errors++;
                $display("FAIL simul_press edge %0d: got %b expected %b", i, press, exp_v);
            end
        end
        n_checks++; if (level !== 2'b11) begin n_errors++; $display("FAIL simul_level: got %b expected 11", level); end
        btn_n = 2'b10;
        for (int i = 1; i <= LAT + 1; i++) begin
            @(negedge Clk);
            exp_v = (i == LAT) ? 2'b10 : 2'b00;
            n_checks++;
            if (release_pulse !== exp_v || press !== 2'b00) begin
                n_errors++;
                $display("FAIL simul_release edge %0d: release=%b press=%b expected %b/00", i, release_pulse, press, exp_v);
            end
        end
        n_checks++; if (level !== 2'b01) begin n_errors++; $display("FAIL simul_level_ch0: got %b expected 01", level); end
        n_checks++; if (any_held !== 1'b1) begin n_errors++; $display("FAIL simul_any_held: got %b expected 1", any_held); end
        btn_n = 2'b11;
        repeat (LAT + 2) @(negedge Clk);
        n_checks++; if (level !== 2'b00 || any_held !== 1'b0) begin n_errors++; $display("FAIL simul_final: level=%b any_held=%b expected 00/0", level, any_held); end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] exp_p;
        @(negedge Clk);
        btn_n[0] = 1'b0;
        repeat (5) @(negedge Clk);   // ARMING entered at edge 3, now two counts in
        reset = 1'b1;
        #1;
        n_checks++;
        if ({level, press, release_pulse, any_held} !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_outputs: got %b expected all zero", {level, press, release_pulse, any_held});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            n_checks++;
            if (press !== 2'b00) begin n_errors++; $display("FAIL reset_mid_hold cycle %0d: press=%b expected 00", i, press); end
        end
        reset = 1'b0;
        for (int i = 1; i <= LAT + 1; i++) begin
            @(negedge Clk);
            exp_p = (i == LAT) ? 2'b01 : 2'b00;
            n_checks++;
            if (press !== exp_p) begin
                n_errors++;
                $display("FAIL reset_mid_press edge %0d: got %b expected %b", i, press, exp_p);
            end
        end
        n_checks++; if (level !== 2'b01) begin n_errors++; $display("FAIL reset_mid_level: got %b expected 01", level); end
        btn_n = '1;
        repeat (LAT + 2) @(negedge Clk);
    endtask

    task automatic test_random_bounce();
        int           hold [N];
        int           dut_press_cnt;
        logic [3*N:0] exp_v;
        dut_press_cnt = 0;
        for (int c = 0; c < N; c++) hold[c] = 0;
        @(negedge Clk);
        sb_q.delete();
        m_press_cnt = 0;
        sb_en = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if (hold[c] == 0) begin
                    btn_n[c] = ~btn_n[c];
                    hold[c]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 12))
                                                           : int'($urandom_range(1, 4));
                end
                hold[c]--;
            end
            @(negedge Clk);
            for (int c = 0; c < N; c++) if (press[c] === 1'b1) dut_press_cnt++;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL random_sb cycle %0d: no expected entry queued", cyc);
            end else begin
                exp_v = sb_q.pop_front();
                if ({level, press, release_pulse, any_held} !== exp_v) begin
                    n_errors++;
                    $display("FAIL random_sb cycle %0d: got %b expected %b (level,press,release,any_held)",
                             cyc, {level, press, release_pulse, any_held}, exp_v);
                end
            end
        end
        sb_en = 1'b0;
        n_checks++;
        if (dut_press_cnt != m_press_cnt) begin
            n_errors++;
            $display("FAIL random_press_count: got %0d expected %0d", dut_press_cnt, m_press_cnt);
        end
        btn_n = '1;
        repeat (LAT + 2) @(negedge Clk);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_random_bounce();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
